uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the reply FIFO entry count; it SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the UART receive stage.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data SHALL be valid in that cycle.
REQ-006 tx_data  output  8  head-of-FIFO byte for the UART transmit stage.
REQ-007 tx_valid  output  1  high while the FIFO is non-empty.
REQ-008 tx_ready  input  1  transmit stage accepts tx_data when tx_valid && tx_ready (pop).
REQ-009 led  output  6  active-low LED drive; led = ~value[5:0].
REQ-010 cmd_err  output  1  one-cycle pulse per rejected command.
REQ-011 ovf  output  1  sticky flag for a dropped push or an ignored rx byte.

Function
REQ-012 Command grammar: 'L' (0x4C) HH term sets an 8-bit value register; 'R' (0x52) term reads it back. HH is two hex digits (0-9, A-F, a-f, high nibble first); term is CR (0x0D) or LF (0x0A).
REQ-013 FSM states: IDLE, L_HI, L_LO, L_TERM, R_TERM, REPLY; transitions occur only on edges where rx_valid=1, except REPLY.
REQ-014 IDLE: 'L'->L_HI; 'R'->R_TERM; CR/LF ignored with no reply; any other byte -> error.
REQ-015 L_HI: hex digit -> latch high nibble, go to L_LO. L_LO: hex digit -> latch low nibble, go to L_TERM. Any other byte in either state -> error.
REQ-016 L_TERM: term -> value <= latched byte, led updates on the same edge, reply 'K' (0x4B). Other byte -> error; value unchanged.
REQ-017 R_TERM: term -> reply two uppercase hex ASCII chars of value, high nibble first. Other byte -> error.
REQ-018 Error: pulse cmd_err for the cycle after the offending byte's edge, queue reply '?' (0x3F), return to IDLE via REPLY.
REQ-019 REPLY: push one reply byte per cycle, starting the edge after the terminating/offending byte; return to IDLE after the last push.
REQ-020 rx_valid arriving while in REPLY SHALL be ignored and SHALL set ovf.
REQ-021 FIFO: FIFO_DEPTH entries; tx_data and tx_valid driven from storage with no combinational path from tx_ready; tx_data SHALL be held stable while tx_valid && !tx_ready.
REQ-022 Full test uses the count before any same-cycle pop; a push when full SHALL be dropped and SHALL set ovf; a simultaneous pop still completes.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-024 Latency: term sampled at edge E -> first reply byte pushed at E+1 -> tx_valid high after E+1.
REQ-025 Pop on empty SHALL have no effect.

Reset
REQ-026 rst SHALL immediately force: FSM=IDLE, value=0x00, led=6'b111111, FIFO empty, tx_valid=0, tx_data=0x00, cmd_err=0, ovf=0.
REQ-027 rst during a partial command or REPLY SHALL discard the command and any queued bytes; no reply SHALL be emitted after release.
REQ-028 ovf SHALL clear only on rst.

Configuration
REQ-029 Macro CMD_ECHO_EN: when defined, every accepted rx byte, including ignored CR/LF, SHALL be pushed to the FIFO on its rx_valid edge, ahead of any reply bytes it triggers; when undefined, only reply bytes are pushed and the echo logic SHALL be absent.

Verification
REQ-030 Bytes "L2A\r", tx_ready=1 -> led=6'b010101, value=0x2A, one byte 0x4B on tx.
REQ-031 After REQ-030, bytes "R\n" -> tx emits 0x32 then 0x41 on consecutive pops.
REQ-032 Bytes "LG" -> cmd_err pulses once, tx emits 0x3F, value and led unchanged, FSM returns to IDLE.
REQ-033 tx_ready=0 with FIFO_DEPTH=4: issue five error bytes ('X') -> four '?' bytes queued, ovf=1; then tx_ready=1 -> exactly four 0x3F bytes emitted.
REQ-034 Assert rst mid-"L2" while the FIFO holds bytes -> outputs take their reset values at once; "L05\n" after release -> led=6'b111010 and a single 'K'.
REQ-035 With CMD_ECHO_EN: "L05\n" -> tx emits 0x4C, 0x30, 0x35, 0x0A, 0x4B, in that order.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: ASCII command parser between a UART receiver and transmitter.
//   "L" HH term : set the 8-bit value register, drive led = ~value[5:0], reply 'K'
//   "R" term    : reply with value as two uppercase hex characters
//   Any malformed byte pulses cmd_err and replies '?'.
// Replies are queued in a FIFO_DEPTH-entry FIFO feeding tx_data/tx_valid.
// Optional build macro CMD_ECHO_EN: echo every accepted rx byte into the FIFO.
module uart_cmd_parser #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [5:0] led,
   output logic       cmd_err,
   output logic       ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {IDLE, L_HI, L_LO, L_TERM, R_TERM, REPLY} state_t;

   state_t        state;
   logic [3:0]    hiNib;
   logic [3:0]    loNib;
   logic [7:0]    value;
   logic [7:0]    replyHi;
   logic [7:0]    replyLo;
   logic          replyTwo;
   logic          replyIdx;
   logic          cmdErr;
   logic          ovfFlag;
   logic          rxBad;
   logic          pushValid;
   logic [7:0]    pushData;
   logic          full;
   logic          pushOk;
   logic          pop;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;

   function automatic logic isHex(input logic [7:0] c);
      isHex = ((c >= 8'h30) && (c <= 8'h39)) ||
              ((c >= 8'h41) && (c <= 8'h46)) ||
              ((c >= 8'h61) && (c <= 8'h66));
   endfunction

   function automatic logic isTerm(input logic [7:0] c);
      isTerm = (c == 8'h0D) || (c == 8'h0A);
   endfunction

   // Digits map straight from the low nibble; letters (either case) have low nibble 1..6.
   function automatic logic [3:0] hexVal(input logic [7:0] c);
      if (c <= 8'h39) begin
         hexVal = c[3:0];
      end else begin
         hexVal = c[3:0] + 4'd9;
      end
   endfunction

   function automatic logic [7:0] toHex(input logic [3:0] n);
      if (n < 4'd10) begin
         toHex = {4'h3, n};
      end else begin
         toHex = 8'h37 + {4'h0, n};
      end
   endfunction

   assign tx_data  = mem[rdPtr];
   assign tx_valid = (count != {CW{1'b0}});
   assign cmd_err  = cmdErr;
   assign ovf      = ovfFlag;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pushOk   = pushValid && !full;
   assign pop      = tx_valid && tx_ready;

   // Decide whether the byte offered in the current state breaks the grammar.
   always_comb begin
      rxBad = 1'b0;
      case (state)
         IDLE:           rxBad = !((rx_data == 8'h4C) || (rx_data == 8'h52) || isTerm(rx_data));
         L_HI, L_LO:     rxBad = !isHex(rx_data);
         L_TERM, R_TERM: rxBad = !isTerm(rx_data);
         default:        rxBad = 1'b0;
      endcase
   end

   // Select the FIFO write source: reply bytes in REPLY, otherwise the optional echo.
   always_comb begin
      pushValid = 1'b0;
      pushData  = 8'h00;
      if (state == REPLY) begin
         pushValid = 1'b1;
         pushData  = replyIdx ? replyLo : replyHi;
      end else begin
`ifdef CMD_ECHO_EN
         pushValid = rx_valid;
         pushData  = rx_data;
`else
         pushValid = 1'b0;
         pushData  = 8'h00;
`endif
      end
   end

   // Command FSM: parse bytes, update value/led, stage reply bytes, raise error and overflow flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hiNib    <= 4'h0;
         loNib    <= 4'h0;
         value    <= 8'h00;
         led      <= 6'b111111;
         replyHi  <= 8'h00;
         replyLo  <= 8'h00;
         replyTwo <= 1'b0;
         replyIdx <= 1'b0;
         cmdErr   <= 1'b0;
         ovfFlag  <= 1'b0;
      end else begin
         cmdErr <= 1'b0;
         if ((pushValid && full) || (rx_valid && (state == REPLY))) begin
            ovfFlag <= 1'b1;
         end
         if (rx_valid && rxBad) begin
            cmdErr   <= 1'b1;
            replyHi  <= 8'h3F;
            replyTwo <= 1'b0;
            replyIdx <= 1'b0;
            state    <= REPLY;
         end else begin
            case (state)
               IDLE: begin
                  if (rx_valid) begin
                     if (rx_data == 8'h4C) begin
                        state <= L_HI;
                     end else if (rx_data == 8'h52) begin
                        state <= R_TERM;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               L_HI: begin
                  if (rx_valid) begin
                     hiNib <= hexVal(rx_data);
                     state <= L_LO;
                  end
               end
               L_LO: begin
                  if (rx_valid) begin
                     loNib <= hexVal(rx_data);
                     state <= L_TERM;
                  end
               end
               L_TERM: begin
                  if (rx_valid) begin
                     value    <= {hiNib, loNib};
                     led      <= ~{hiNib[1:0], loNib};
                     replyHi  <= 8'h4B;
                     replyTwo <= 1'b0;
                     replyIdx <= 1'b0;
                     state    <= REPLY;
                  end
               end
               R_TERM: begin
                  if (rx_valid) begin
                     replyHi  <= toHex(value[7:4]);
                     replyLo  <= toHex(value[3:0]);
                     replyTwo <= 1'b1;
                     replyIdx <= 1'b0;
                     state    <= REPLY;
                  end
               end
               REPLY: begin
                  if (replyTwo && !replyIdx) begin
                     replyIdx <= 1'b1;
                  end else begin
                     replyIdx <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Reply FIFO: full test uses the pre-pop count, so a push into a full FIFO drops even if a pop occurs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wrPtr <= {PW{1'b0}};
         rdPtr <= {PW{1'b0}};
         count <= {CW{1'b0}};
      end else begin
         if (pushOk) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({pushOk, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (FIFO_DEPTH = 4).
module tb_uart_cmd_parser;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [5:0] led;
   logic       cmd_err;
   logic       ovf;

   int         total;
   int         bad;
   int         errCnt;
   logic [7:0] txq[$];

   uart_cmd_parser #(.FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .led      (led),
      .cmd_err  (cmd_err),
      .ovf      (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record popped bytes and cmd_err pulses midway between rising edges.
   always @(negedge clk) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
      if (cmd_err === 1'b1) errCnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qAt(input int i);
      if (i < txq.size()) return txq[i];
      else return 8'hxx;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(posedge clk); #2;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #2;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] echoExp [5];
      total = 0; bad = 0; errCnt = 0;
      rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_led", led, 6'b111111);
      chk("rst_cmd_err", cmd_err, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      waitCycles(2);
      rst = 1'b0;
      waitCycles(2);

`ifdef CMD_ECHO_EN
      txq.delete();
      sendByte(8'h4C); sendByte(8'h30); sendByte(8'h35); sendByte(8'h0A);
      waitCycles(8);
      echoExp = '{8'h4C, 8'h30, 8'h35, 8'h0A, 8'h4B};
      chk("echo_count", txq.size(), 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("echo_byte%0d", i), qAt(i), echoExp[i]);
      chk("echo_led", led, 6'b111010);
`else
      echoExp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      // "L2A\r": value 0x2A, reply 'K' one cycle after the terminator edge
      txq.delete();
      sendByte(8'h4C); sendByte(8'h32); sendByte(8'h41); sendByte(8'h0D);
      chk("lat_not_yet", tx_valid, 1'b0);
      @(posedge clk); #2;
      chk("lat_valid", tx_valid, 1'b1);
      chk("lat_data", tx_data, 8'h4B);
      waitCycles(6);
      chk("set_led", led, 6'b010101);
      chk("set_count", txq.size(), 32'd1);
      chk("set_reply", qAt(0), 8'h4B);
      chk("set_ovf", ovf, 1'b0);

      // "R\n": read back as '2','A'
      txq.delete();
      sendByte(8'h52); sendByte(8'h0A);
      waitCycles(6);
      chk("rd_count", txq.size(), 32'd2);
      chk("rd_hi", qAt(0), 8'h32);
      chk("rd_lo", qAt(1), 8'h41);

      // "LG": bad hex digit -> one cmd_err pulse and '?', value untouched
      txq.delete(); errCnt = 0;
      sendByte(8'h4C); sendByte(8'h47);
      waitCycles(6);
      chk("err_pulses", errCnt, 32'd1);
      chk("err_count", txq.size(), 32'd1);
      chk("err_reply", qAt(0), 8'h3F);
      chk("err_led", led, 6'b010101);
      txq.delete();
      sendByte(8'h52); sendByte(8'h0D);
      waitCycles(6);
      chk("err_idle_hi", qAt(0), 8'h32);
      chk("err_idle_lo", qAt(1), 8'h41);

      // Lowercase hex "Lab\r" then "R\r" -> uppercase 'A','B'
      txq.delete();
      sendByte(8'h4C); sendByte(8'h61); sendByte(8'h62); sendByte(8'h0D);
      waitCycles(6);
      chk("lc_led", led, 6'b010100);
      txq.delete();
      sendByte(8'h52); sendByte(8'h0D);
      waitCycles(6);
      chk("lc_hi", qAt(0), 8'h41);
      chk("lc_lo", qAt(1), 8'h42);

      // Full FIFO: five 'X' with tx stalled -> four '?' kept, fifth dropped
      tx_ready = 1'b0;
      txq.delete(); errCnt = 0;
      for (int i = 0; i < 4; i++) sendByte(8'h58);
      waitCycles(3);
      chk("full_ovf_before", ovf, 1'b0);
      chk("full_hold_data", tx_data, 8'h3F);
      sendByte(8'h58);
      waitCycles(3);
      chk("full_ovf", ovf, 1'b1);
      chk("full_valid", tx_valid, 1'b1);
      chk("full_errs", errCnt, 32'd5);
      chk("full_no_pop", txq.size(), 32'd0);
      tx_ready = 1'b1;
      waitCycles(8);
      chk("drain_count", txq.size(), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("drain_byte%0d", i), qAt(i), 8'h3F);
      chk("drain_empty", tx_valid, 1'b0);
      chk("ovf_sticky", ovf, 1'b1);

      // Reset mid "L2" with queued bytes
      tx_ready = 1'b0;
      txq.delete();
      sendByte(8'h52); sendByte(8'h0D);
      waitCycles(4);
      sendByte(8'h4C); sendByte(8'h32);
      chk("pre_rst_valid", tx_valid, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", tx_valid, 1'b0);
      chk("mid_rst_data", tx_data, 8'h00);
      chk("mid_rst_led", led, 6'b111111);
      chk("mid_rst_ovf", ovf, 1'b0);
      chk("mid_rst_err", cmd_err, 1'b0);
      waitCycles(1);
      rst = 1'b0;
      tx_ready = 1'b1;
      waitCycles(6);
      chk("post_rst_silent", txq.size(), 32'd0);
      sendByte(8'h4C); sendByte(8'h30); sendByte(8'h35); sendByte(8'h0A);
      waitCycles(6);
      chk("post_rst_led", led, 6'b111010);
      chk("post_rst_count", txq.size(), 32'd1);
      chk("post_rst_reply", qAt(0), 8'h4B);
      chk("post_rst_echo_unused", echoExp[0], 8'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
